// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control blocks.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare of decode sources against the load destination in execute.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_writereg,
  output logic       o_hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_id_uses_rs && (i_id_rs == i_ex_writereg);
  assign w_rt_hit = i_id_uses_rt && (i_id_rt == i_ex_writereg);

  // Writes to r0 are discarded, so a load into r0 never creates a dependency.
  assign o_hazard = i_ex_memread && (i_ex_writereg != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer: load-use stalls, branch flushes, memory freeze with timeout abort.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             i_id_rs,
  input  logic [4:0]             i_id_rt,
  input  logic                   i_id_uses_rs,
  input  logic                   i_id_uses_rt,
  input  logic                   i_ex_memread,
  input  logic [4:0]             i_ex_writereg,
  input  logic                   i_ex_branch_taken,
  input  logic                   i_dmem_req_m,
  input  logic                   i_dmem_ready,
  output logic                   o_stall_f,
  output logic                   o_stall_d,
  output logic                   o_stall_e,
  output logic                   o_stall_m,
  output logic                   o_clr_d,
  output logic                   o_clr_e,
  output logic                   o_clr_m,
  output logic                   o_clr_w,
  output logic                   o_mem_err,
  output logic [STALL_CNT_W-1:0] o_stall_cycles
);

  localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [WCNT_W-1:0]      r_wait_cnt;
  logic [WCNT_W-1:0]      w_wait_cnt_next;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   w_freeze;
  logic                   w_load_use;

  load_use_detect u_load_use_detect (
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_uses_rs  (i_id_uses_rs),
    .i_id_uses_rt  (i_id_uses_rt),
    .i_ex_memread  (i_ex_memread),
    .i_ex_writereg (i_ex_writereg),
    .o_hazard      (w_load_use)
  );

  assign w_freeze = ((r_state == RUN) && i_dmem_req_m && !i_dmem_ready) ||
                    ((r_state == MEM_WAIT) && !i_dmem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    unique case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_state_next    = MEM_WAIT;
          w_wait_cnt_next = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // Ready is checked first so a completion on the last allowed cycle never aborts.
        if (i_dmem_ready) begin
          w_state_next    = RUN;
          w_wait_cnt_next = '0;
        end else if (r_wait_cnt == WCNT_LAST) begin
          w_state_next    = ABORT;
          w_wait_cnt_next = '0;
        end else begin
          w_wait_cnt_next = r_wait_cnt + WCNT_W'(1);
        end
      end
      ABORT: begin
        w_state_next    = RUN;
        w_wait_cnt_next = '0;
      end
      default: begin
        w_state_next    = RUN;
        w_wait_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_stall_m = 1'b0;
    o_clr_d   = 1'b0;
    o_clr_e   = 1'b0;
    o_clr_m   = 1'b0;
    o_clr_w   = 1'b0;
    o_mem_err = 1'b0;
    if (!reset) begin
      if (r_state == ABORT) begin
        o_stall_f = 1'b1;
        o_clr_d   = 1'b1;
        o_clr_e   = 1'b1;
        o_clr_m   = 1'b1;
        o_clr_w   = 1'b1;
        o_mem_err = 1'b1;
      end else if (w_freeze) begin
        // MEM/WB has no enable; clearing it stops the frozen load writing back twice.
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_stall_e = 1'b1;
        o_stall_m = 1'b1;
        o_clr_w   = 1'b1;
      end else if (i_ex_branch_taken) begin
        o_clr_d = 1'b1;
        o_clr_e = 1'b1;
      end else if (w_load_use) begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_clr_e   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (o_stall_f && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the five-stage integer pipeline. Detects load-use hazards in decode, flushes younger stages on taken branches resolved in execute, and freezes the pipeline while the data memory withholds `dmem_ready`. It drives the stall and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A timeout FSM aborts a hung memory access and flushes the pipe.

## Interface
- `TIMEOUT`, 16: consecutive frozen cycles allowed before a memory access is aborted (≥2).
- `STALL_CNT_W`, 16: width of the stall performance counter.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `id_rs`, `id_rt` in 5 each: source registers of the instruction in decode.
- `id_uses_rs`, `id_uses_rt` in 1 each: decode instruction actually reads rs / rt.
- `ex_memread` in 1: instruction in execute is a load.
- `ex_writereg` in 5: destination register of the instruction in execute.
- `ex_branch_taken` in 1: branch in execute resolved taken (redirect).
- `dmem_req_m` in 1: instruction in memory stage accesses data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1 each: hold PC / IF/ID / ID/EX / EX/MEM.
- `clr_d`, `clr_e`, `clr_m`, `clr_w` out 1 each: clear IF/ID / ID/EX / EX/MEM / MEM/WB to a bubble.
- `mem_err` out 1: access aborted (one-cycle pulse).
- `stall_cycles` out `STALL_CNT_W`: saturating count of cycles with `stall_f`=1.

## Operation
- FSM states: RUN, MEM_WAIT, ABORT. Reset state RUN. `wait_cnt` is cleared to 0.
- freeze = (RUN and `dmem_req_m` and not `dmem_ready`) or (MEM_WAIT and not `dmem_ready`).
- When freeze=1:
  - `stall_f`, `stall_d`, `stall_e` and `stall_m` are 1.
  - `clr_w`=1. MEM/WB has no enable, so this prevents a duplicate writeback.
  - Branch and load-use outputs are suppressed. The branch stays in execute and is re-evaluated after release.
- Load-use (RUN, freeze=0): `ex_memread` and `ex_writereg`≠0 and ((`id_uses_rs` and `id_rs`==`ex_writereg`) or (`id_uses_rt` and `id_rt`==`ex_writereg`)).
  - Response: `stall_f`=`stall_d`=1 and `clr_e`=1.
- Taken branch (RUN, freeze=0): `clr_d`=`clr_e`=1 and `stall_f`=0.
  - Takes priority over a simultaneous load-use, because the decode instruction is squashed.
- Transitions:
  - RUN→MEM_WAIT when freeze=1 in RUN; `wait_cnt`←1.
  - MEM_WAIT→RUN when `dmem_ready`=1, with freeze released that cycle.
  - MEM_WAIT→ABORT when `dmem_ready`=0 and `wait_cnt`==`TIMEOUT`−1.
  - Otherwise MEM_WAIT stays and `wait_cnt` increments.
  - ABORT→RUN unconditionally.
- ABORT cycle:
  - `clr_d`=`clr_e`=`clr_m`=`clr_w`=1, `stall_f`=1, `mem_err`=1, all other outputs 0.
  - `dmem_ready` and `dmem_req_m` are ignored.
- `stall_cycles` increments on every cycle with `stall_f`=1 and saturates at all-ones. Only reset clears it.
- All outputs other than the two counters are combinational from state and inputs. While `reset`=1 every output is 0.

## Timing
- Hazard responses act in the same cycle as the causing inputs. Pipeline registers react at the next `clk` edge.
- Memory stall with ready low from cycle 0:
  - Freeze is active in cycles 0..`TIMEOUT`−1.
  - ABORT occurs in cycle `TIMEOUT`; `mem_err` is high for that cycle only.
  - RUN resumes in cycle `TIMEOUT`+1.
- If `dmem_ready` rises in cycle k ≤ `TIMEOUT`−1: freeze=0 in cycle k, and readdata is captured into MEM/WB at the end of cycle k.
- If ready arrives in the same cycle as the timeout compare, ready wins: no abort.
- Load-use costs exactly one bubble cycle. A taken branch costs two squashed instructions.
- Reset mid-MEM_WAIT: state→RUN, `wait_cnt`→0, `stall_cycles`→0 immediately (asynchronous).

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state enum {RUN, MEM_WAIT, ABORT};
  - constant `REG_ZERO`=5'd0.
- Sub-module `load_use_detect`: combinational compare of rs/rt against `ex_writereg`, including the `REG_ZERO` exclusion. It is reused by the dual-issue decoder.

## Test plan
- `ex_memread`=1, `ex_writereg`=5, `id_rs`=5, `id_uses_rs`=1, no memory request → one cycle of `stall_f`=`stall_d`=`clr_e`=1. Repeat with `ex_writereg`=0 → all outputs 0.
- Same load-use plus `ex_branch_taken`=1 → `clr_d`=`clr_e`=1, `stall_f`=0.
- `dmem_req_m`=1 with `dmem_ready` low for 3 cycles → freeze and `clr_w` for 3 cycles, release in cycle 3, `stall_cycles`=3.
- `dmem_ready` never rises, `TIMEOUT`=16 → freeze cycles 0–15, `mem_err` plus all clr outputs in cycle 16, RUN in cycle 17.
- Ready rises exactly at cycle 15 → no ABORT and `mem_err` stays 0. Separately, assert `reset` mid-MEM_WAIT → all outputs 0 at once and RUN after release.
- Force 2^16+5 stall cycles → `stall_cycles` holds at 16'hFFFF.
